rsbus_r2d_rdy_ctrl: RTL

//  Credit-based ready controller for the r2d extractor's frame-output port (frm_o_*).

---
 rtl/rsbus_r2d_rdy_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rsbus_r2d_rdy_ctrl.sv
// rtl/rsbus_r2d_rdy_ctrl.sv - per-channel short/long credit tracking and frm_o_rdy generation for the r2d frame port
// Define RSBUS_R2D_RDY_CTRL_STATS_EN to add the stat_frm/stat_stall counters.
module rsbus_r2d_rdy_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int S_CREDITS  = 4,
  parameter int L_CREDITS  = 2,
  parameter int S_WORDS    = 2,
  parameter int L_WORDS    = 9,
  parameter int RDY_MARGIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_i_stb,
  input  logic        frm_i_sof,
  input  logic [3:0]  frm_i_iid,
  input  logic [71:0] frm_i_bus,
  output logic [1:0]  frm_o_rdy,
  input  logic        ret_stb,
  input  logic [3:0]  ret_iid,
  input  logic        ret_len,
  output logic [3:0]  err_o,
  input  logic        err_clr
`ifdef RSBUS_R2D_RDY_CTRL_STATS_EN
  ,
  output logic [31:0] stat_frm,
  output logic [31:0] stat_stall
`endif
);

  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);
  localparam logic [3:0] S_MAX    = 4'(S_CREDITS);
  localparam logic [3:0] L_MAX    = 4'(L_CREDITS);
  localparam logic [3:0] MARGIN   = 4'(RDY_MARGIN);
  localparam logic [7:0] S_LOAD   = 8'(S_WORDS - 1);
  localparam logic [7:0] L_LOAD   = 8'(L_WORDS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [3:0] s_cnt_q [NUM_CH];
  logic [3:0] s_cnt_d [NUM_CH];
  logic [3:0] l_cnt_q [NUM_CH];
  logic [3:0] l_cnt_d [NUM_CH];
  logic [5:0] s_upd   [NUM_CH];
  logic [5:0] l_upd   [NUM_CH];
  logic [1:0] rdy_q, rdy_d;
  logic [3:0] err_q, err_d;
  logic [0:0] state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] load;

  logic frm_len, frm_iid_ok, ret_iid_ok, cons, ret_ok;
  logic uflow, oflow, frame_err, bad_iid;
  logic unused_bus;

  assign frm_len    = frm_i_bus[39];
  assign unused_bus = ^{frm_i_bus[71:40], frm_i_bus[38:0]};
  assign frm_iid_ok = {1'b0, frm_i_iid} < NUM_CH_W;
  assign ret_iid_ok = {1'b0, ret_iid} < NUM_CH_W;
  assign cons       = frm_i_stb && frm_i_sof && frm_iid_ok;
  assign ret_ok     = ret_stb && ret_iid_ok;
  assign bad_iid    = (frm_i_stb && frm_i_sof && !frm_iid_ok) || (ret_stb && !ret_iid_ok);

  // Result is {underflow, overflow, next_count}; a consume and return on the same counter cancel.
  function automatic logic [5:0] cnt_upd(input logic [3:0] cnt, input logic [3:0] max_v,
                                         input logic dec, input logic inc);
    logic [5:0] r;
    r = {2'b00, cnt};
    if (dec && !inc) begin
      if (cnt == 4'd0) r[5] = 1'b1;
      else             r[3:0] = cnt - 4'd1;
    end else if (inc && !dec) begin
      if (cnt >= max_v) r[4] = 1'b1;
      else              r[3:0] = cnt + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    uflow = 1'b0;
    oflow = 1'b0;
    rdy_d = 2'b11;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      s_upd[ch] = cnt_upd(s_cnt_q[ch], S_MAX,
                          cons && !frm_len && (frm_i_iid == 4'(ch)),
                          ret_ok && !ret_len && (ret_iid == 4'(ch)));
      l_upd[ch] = cnt_upd(l_cnt_q[ch], L_MAX,
                          cons && frm_len && (frm_i_iid == 4'(ch)),
                          ret_ok && ret_len && (ret_iid == 4'(ch)));
      s_cnt_d[ch] = s_upd[ch][3:0];
      l_cnt_d[ch] = l_upd[ch][3:0];
      uflow = uflow | s_upd[ch][5] | l_upd[ch][5];
      oflow = oflow | s_upd[ch][4] | l_upd[ch][4];
      // Ready looks at the registered counts, giving one cycle of latency.
      rdy_d[0] = rdy_d[0] & (s_cnt_q[ch] > MARGIN);
      rdy_d[1] = rdy_d[1] & (l_cnt_q[ch] > MARGIN);
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    frame_err = 1'b0;
    load      = frm_len ? L_LOAD : S_LOAD;
    if (frm_i_stb) begin
      if (frm_i_sof) begin
        frame_err = (state_q == ST_BODY);
        wcnt_d    = load;
        state_d   = (load == 8'd0) ? ST_IDLE : ST_BODY;
      end else if (state_q == ST_IDLE) begin
        frame_err = 1'b1;
      end else begin
        wcnt_d = wcnt_q - 8'd1;
        if (wcnt_q == 8'd1) state_d = ST_IDLE;
      end
    end
  end

  assign err_d = (err_clr ? 4'b0000 : err_q) | {bad_iid, frame_err, oflow, uflow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        s_cnt_q[ch] <= S_MAX;
        l_cnt_q[ch] <= L_MAX;
      end
      rdy_q   <= 2'b00;
      err_q   <= 4'b0000;
      state_q <= ST_IDLE;
      wcnt_q  <= 8'd0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        s_cnt_q[ch] <= s_cnt_d[ch];
        l_cnt_q[ch] <= l_cnt_d[ch];
      end
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign frm_o_rdy = rdy_q;
  assign err_o     = err_q;

`ifdef RSBUS_R2D_RDY_CTRL_STATS_EN
  logic [31:0] stat_frm_q, stat_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frm_q   <= 32'd0;
      stat_stall_q <= 32'd0;
    end else if (err_clr) begin
      stat_frm_q   <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      if (cons) stat_frm_q <= stat_frm_q + 32'd1;
      if (rdy_q != 2'b11) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_frm   = stat_frm_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
